// File: rtl/decode_stage_pipe_pkg.sv
// ISA field layout and opcode constants shared by the decode stage.
// Instruction fields: opType[31:30] opCode[29:26] Rd[25:22] Ra[21:18] Rb[17:14] imm[17:0].
package isa_pkg;

    localparam int OPT_LSB = 30;
    localparam int OPC_LSB = 26;
    localparam int RD_LSB  = 22;
    localparam int RA_LSB  = 18;
    localparam int RB_LSB  = 14;
    localparam int IMM_LSB = 0;

    typedef logic [1:0] op_type_t;
    typedef logic [3:0] op_code_t;

    localparam op_type_t OPT_MEM  = 2'b01;
    localparam op_code_t OP_LOAD  = 4'b0000;
    localparam op_code_t OP_STORE = 4'b0001;

    function automatic logic is_mem_op(op_type_t t, op_code_t c, op_code_t want);
        return (t == OPT_MEM) && (c == want);
    endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch/writeback/bypass inputs and ID/EX outputs of the decode stage.
// The master side drives instructions in; the slave side is the decode stage.
interface decode_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
);
    logic              id_valid;
    logic [31:0]       inst;
    logic [DATA_W-1:0] pc4;
    logic              imm_src;
    logic              branch_flag;
    logic              wb_we;
    logic [IDX_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              mem_fwd_we;
    logic [IDX_W-1:0]  mem_fwd_rd;
    logic [DATA_W-1:0] mem_fwd_data;
    logic              ex_stall;
    logic              flush;
    logic              id_stall;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_op1;
    logic [DATA_W-1:0] ex_op2;
    logic [DATA_W-1:0] ex_store_data;
    logic [IDX_W-1:0]  ex_rd;
    logic [1:0]        ex_op_type;
    logic [3:0]        ex_op_code;

    modport master (
        output id_valid, inst, pc4, imm_src, branch_flag,
               wb_we, wb_rd, wb_data, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
               ex_stall, flush,
        input  id_stall, ex_valid, ex_op1, ex_op2, ex_store_data,
               ex_rd, ex_op_type, ex_op_code
    );

    modport slave (
        input  id_valid, inst, pc4, imm_src, branch_flag,
               wb_we, wb_rd, wb_data, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
               ex_stall, flush,
        output id_stall, ex_valid, ex_op1, ex_op2, ex_store_data,
               ex_rd, ex_op_type, ex_op_code
    );

endinterface

// File: rtl/decode_stage_pipe_reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port,
// synchronous clear of every entry. No hardwired-zero register.
module reg_file #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];

    // Storage update: clear all on reset, otherwise single-port write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_r[raddr_a];
    assign rdata_b = regs_r[raddr_b];

endmodule

// File: rtl/decode_stage_pipe.sv
// Instruction decode stage: operand selection with EX/MEM and writeback bypass,
// load-use bubble insertion and a stallable/flushable ID/EX register.
module decode_stage_pipe
    import isa_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int IMM_W    = 18
) (
    input logic                clk,
    input logic                rst,
    decode_stage_pipe_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [IDX_W-1:0]  ra_s;
    logic [IDX_W-1:0]  rb_s;
    logic [IDX_W-1:0]  rd_s;
    op_type_t          op_type_s;
    op_code_t          op_code_s;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] rf_a_s;
    logic [DATA_W-1:0] rf_b_s;
    logic [DATA_W-1:0] src_a_s;
    logic [DATA_W-1:0] src_b_s;
    logic [DATA_W-1:0] op1_s;
    logic [DATA_W-1:0] op2_s;
    logic              is_store_s;
    logic              ex_is_load_s;
    logic              hazard_s;

    logic              ex_valid_r;
    logic [DATA_W-1:0] ex_op1_r;
    logic [DATA_W-1:0] ex_op2_r;
    logic [DATA_W-1:0] ex_store_data_r;
    logic [IDX_W-1:0]  ex_rd_r;
    op_type_t          ex_op_type_r;
    op_code_t          ex_op_code_r;

    assign op_type_s = bus.inst[OPT_LSB +: 2];
    assign op_code_s = bus.inst[OPC_LSB +: 4];
    assign rd_s      = bus.inst[RD_LSB +: IDX_W];
    assign ra_s      = bus.inst[RA_LSB +: IDX_W];
    assign rb_s      = bus.inst[RB_LSB +: IDX_W];
    assign imm_s     = DATA_W'($signed(bus.inst[IMM_LSB +: IMM_W]));

    reg_file #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.wb_we),
        .waddr   (bus.wb_rd),
        .wdata   (bus.wb_data),
        .raddr_a (ra_s),
        .rdata_a (rf_a_s),
        .raddr_b (rb_s),
        .rdata_b (rf_b_s)
    );

    // Ra source: the younger EX/MEM result beats the writeback value.
    always_comb begin
        src_a_s = rf_a_s;
        if (bus.mem_fwd_we && (bus.mem_fwd_rd == ra_s)) begin
            src_a_s = bus.mem_fwd_data;
        end else if (bus.wb_we && (bus.wb_rd == ra_s)) begin
            src_a_s = bus.wb_data;
        end else begin
            src_a_s = rf_a_s;
        end
    end

    // Rb source, same priority; also feeds store data.
    always_comb begin
        src_b_s = rf_b_s;
        if (bus.mem_fwd_we && (bus.mem_fwd_rd == rb_s)) begin
            src_b_s = bus.mem_fwd_data;
        end else if (bus.wb_we && (bus.wb_rd == rb_s)) begin
            src_b_s = bus.wb_data;
        end else begin
            src_b_s = rf_b_s;
        end
    end

    assign op1_s = bus.branch_flag ? (bus.pc4 + DATA_W'(3'd4)) : src_a_s;
    assign op2_s = bus.imm_src ? imm_s : src_b_s;

    // A store reads Rb for its data even when op2 is the immediate.
    assign is_store_s   = is_mem_op(op_type_s, op_code_s, OP_STORE);
    assign ex_is_load_s = ex_valid_r && is_mem_op(ex_op_type_r, ex_op_code_r, OP_LOAD);

    // Load-use check against the sources this instruction actually reads.
    always_comb begin
        hazard_s = 1'b0;
        if (ex_is_load_s && bus.id_valid) begin
            hazard_s = ((!bus.branch_flag) && (ex_rd_r == ra_s)) ||
                       ((!bus.imm_src || is_store_s) && (ex_rd_r == rb_s));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign bus.id_stall = bus.ex_stall | (hazard_s & ~rst);

    // ID/EX register: flush beats stall, stall beats bubble, bubble beats load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r      <= 1'b0;
            ex_op1_r        <= '0;
            ex_op2_r        <= '0;
            ex_store_data_r <= '0;
            ex_rd_r         <= '0;
            ex_op_type_r    <= '0;
            ex_op_code_r    <= '0;
        end else if (bus.flush) begin
            ex_valid_r <= 1'b0;
        end else if (bus.ex_stall) begin
            ex_valid_r <= ex_valid_r;
        end else if (hazard_s) begin
            ex_valid_r <= 1'b0;
        end else begin
            ex_valid_r      <= bus.id_valid;
            ex_op1_r        <= op1_s;
            ex_op2_r        <= op2_s;
            ex_store_data_r <= src_b_s;
            ex_rd_r         <= rd_s;
            ex_op_type_r    <= op_type_s;
            ex_op_code_r    <= op_code_s;
        end
    end

    assign bus.ex_valid      = ex_valid_r;
    assign bus.ex_op1        = ex_op1_r;
    assign bus.ex_op2        = ex_op2_r;
    assign bus.ex_store_data = ex_store_data_r;
    assign bus.ex_rd         = ex_rd_r;
    assign bus.ex_op_type    = ex_op_type_r;
    assign bus.ex_op_code    = ex_op_code_r;

endmodule
